// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if: digit inputs, enable, colon strobe and
// the multiplexed segment/anode outputs of the display driver.
interface seg_display_mux_if;
  logic       en_i;
  logic [3:0] seconds_units_i;
  logic [3:0] seconds_tens_i;
  logic [3:0] minutes_units_i;
  logic [3:0] minutes_tens_i;
  logic       colon_pulse_i;
  logic [6:0] seg_o;
  logic       dp_o;
  logic [3:0] an_o;
  logic       frame_done_o;

  modport master (
    output en_i,
    output seconds_units_i,
    output seconds_tens_i,
    output minutes_units_i,
    output minutes_tens_i,
    output colon_pulse_i,
    input  seg_o,
    input  dp_o,
    input  an_o,
    input  frame_done_o
  );

  modport slave (
    input  en_i,
    input  seconds_units_i,
    input  seconds_tens_i,
    input  minutes_units_i,
    input  minutes_tens_i,
    input  colon_pulse_i,
    output seg_o,
    output dp_o,
    output an_o,
    output frame_done_o
  );
endinterface

// File: rtl/seg_display_mux.sv
// seg_display_mux: 4-digit 7-segment scanner with per-frame
// snapshot, ghost blanking, leading-zero blank and colon blink.
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES    = 16,
  parameter bit          BLANK_LEAD_ZERO = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  seg_display_mux_if.slave bus
);

  localparam int unsigned CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic            colon_q, colon_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic            fd_q, fd_d;

  logic            snap;
  logic            blank;
  logic            lead_zero;
  logic [3:0]      cur;
  logic [6:0]      seg_l;
  logic            dp_l;
  logic [3:0]      an_l;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h7E;
      4'd1:    decode = 7'h30;
      4'd2:    decode = 7'h6D;
      4'd3:    decode = 7'h79;
      4'd4:    decode = 7'h33;
      4'd5:    decode = 7'h5B;
      4'd6:    decode = 7'h5F;
      4'd7:    decode = 7'h70;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h7B;
      default: decode = 7'h01;
    endcase
  endfunction

  // scan position, frame snapshot and colon toggle
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    snap     = (cnt_q == '0) && (idx_q == 2'd0);
    colon_d  = colon_q ^ bus.colon_pulse_i;
    if (!bus.en_i) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (snap) begin
      shadow_d[0] = bus.seconds_units_i;
      shadow_d[1] = bus.seconds_tens_i;
      shadow_d[2] = bus.minutes_units_i;
      shadow_d[3] = bus.minutes_tens_i;
    end
  end

  // slot output in logical polarity, then physical polarity
  always_comb begin
    cur       = shadow_q[idx_q];
    blank     = !bus.en_i || (32'(cnt_q) < BLANK_CYCLES);
    lead_zero = BLANK_LEAD_ZERO && (idx_q == 2'd3)
                && (cur == 4'd0);
    seg_l     = blank ? 7'h00 : decode(cur);
    an_l      = (blank || lead_zero) ? 4'h0
                                     : (4'b0001 << idx_q);
    dp_l      = !blank && (idx_q == 2'd2) && colon_q;
    seg_d     = seg_l ^ {7{ACTIVE_LOW}};
    dp_d      = dp_l ^ ACTIVE_LOW;
    an_d      = an_l ^ {4{ACTIVE_LOW}};
    fd_d      = bus.en_i && (idx_q == 2'd3)
                && (cnt_q == CNT_LAST);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= '0;
      colon_q  <= 1'b0;
      seg_q    <= {7{ACTIVE_LOW}};
      dp_q     <= ACTIVE_LOW;
      an_q     <= {4{ACTIVE_LOW}};
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      colon_q  <= colon_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.seg_o        = seg_q;
  assign bus.dp_o         = dp_q;
  assign bus.an_o         = an_q;
  assign bus.frame_done_o = fd_q;

endmodule
